// File: rtl/rca_64.sv
// rtl/rca_64.sv - two-stage pipelined 64-bit ripple-carry adder (optional ovf output via RCA_64_OVF_EN)

module rca_64_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    logic p;

    assign p    = a_i ^ b_i;
    assign s_o  = p ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & p);
endmodule

module rca_64 (
    output logic [63:0] sum,
    output logic        crout,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    input  logic        clock,
    input  logic        reset
`ifdef RCA_64_OVF_EN
    ,
    output logic        ovf
`endif
);
    logic [63:0] a_q, b_q;
    logic [63:0] sum_q, sum_d;
    logic        crout_q, crout_d;
    logic [64:0] carry;

    assign carry[0] = 1'b0;

    // Bit i's carry-out feeds bit i+1; the full chain settles within stage 2.
    for (genvar i = 0; i < 64; i++) begin : g_cell
        rca_64_fa u_fa (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .c_i  (carry[i]),
            .s_o  (sum_d[i]),
            .co_o (carry[i+1])
        );
    end

    assign crout_d = carry[64];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            crout_q <= 1'b0;
        end else begin
            a_q     <= op1;
            b_q     <= op2;
            sum_q   <= sum_d;
            crout_q <= crout_d;
        end
    end

    assign sum   = sum_q;
    assign crout = crout_q;

`ifdef RCA_64_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf_d = (a_q[63] == b_q[63]) && (sum_d[63] != a_q[63]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_rca_64.sv
// tb/tb_rca_64.sv - directed self-checking bench for rca_64

module tb_rca_64;
    logic [63:0] sum;
    logic        crout;
    logic [63:0] op1, op2;
    logic        clock;
    logic        reset;
`ifdef RCA_64_OVF_EN
    logic        ovf;
`endif

    int n_vec;
    int n_err;

    rca_64 dut (
        .sum   (sum),
        .crout (crout),
        .op1   (op1),
        .op2   (op2),
        .clock (clock),
        .reset (reset)
`ifdef RCA_64_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic edge_wait();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op1   = '0;
        op2   = '0;
        #3;
        n_vec++;
        if (sum !== 64'h0) begin n_err++; $display("FAIL reset_sum: got %h expected %h", sum, 64'h0); end
        n_vec++;
        if (crout !== 1'b0) begin n_err++; $display("FAIL reset_crout: got %b expected 0", crout); end
`ifdef RCA_64_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        #1;
        reset = 1'b0;
        edge_wait();
        edge_wait();
        n_vec++;
        if (sum !== 64'h0 || crout !== 1'b0)
        begin n_err++; $display("FAIL reset_release: got %h/%b expected 0/0", sum, crout); end
    endtask

    task automatic test_basic();
        op1 = 64'h1010_1010_1199_FFFF;
        op2 = 64'hABCD_1100_1100_DDDD;
        edge_wait();
        n_vec++;
        if (sum !== 64'h0) begin n_err++; $display("FAIL basic_latency1: got %h expected %h", sum, 64'h0); end
        edge_wait();
        n_vec++;
        if (sum !== 64'hBBDD_2110_229A_DDDC)
        begin n_err++; $display("FAIL basic_sum: got %h expected %h", sum, 64'hBBDD_2110_229A_DDDC); end
        n_vec++;
        if (crout !== 1'b0) begin n_err++; $display("FAIL basic_crout: got %b expected 0", crout); end
    endtask

    task automatic test_full_ripple();
        op1 = 64'hFFFF_FFFF_FFFF_FFFF;
        op2 = 64'h1;
        edge_wait();
        edge_wait();
        n_vec++;
        if (sum !== 64'h0) begin n_err++; $display("FAIL ripple_sum: got %h expected %h", sum, 64'h0); end
        n_vec++;
        if (crout !== 1'b1) begin n_err++; $display("FAIL ripple_crout: got %b expected 1", crout); end
`ifdef RCA_64_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ripple_ovf: got %b expected 0", ovf); end
`endif
    endtask

    task automatic test_overflow();
        op1 = 64'h8000_0000_0000_0000;
        op2 = 64'h8000_0000_0000_0000;
        edge_wait();
        op1 = 64'h7FFF_FFFF_FFFF_FFFF;
        op2 = 64'h1;
        edge_wait();
        n_vec++;
        if (sum !== 64'h0 || crout !== 1'b1)
        begin n_err++; $display("FAIL neg_ovf: got %h/%b expected 0/1", sum, crout); end
`ifdef RCA_64_OVF_EN
        n_vec++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL neg_ovf_flag: got %b expected 1", ovf); end
`endif
        edge_wait();
        n_vec++;
        if (sum !== 64'h8000_0000_0000_0000 || crout !== 1'b0)
        begin n_err++; $display("FAIL pos_ovf: got %h/%b expected 8000000000000000/0", sum, crout); end
`ifdef RCA_64_OVF_EN
        n_vec++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL pos_ovf_flag: got %b expected 1", ovf); end
`endif
    endtask

    task automatic test_hold();
        op1 = 64'h0000_0000_FFFF_FFFF;
        op2 = 64'h1;
        edge_wait();
        #2;
        op1 = 64'd5;
        op2 = 64'd5;
        #1;
        n_vec++;
        if (sum !== 64'h8000_0000_0000_0000)
        begin n_err++; $display("FAIL hold_mid: got %h expected %h", sum, 64'h8000_0000_0000_0000); end
        edge_wait();
        n_vec++;
        if (sum !== 64'h0000_0001_0000_0000 || crout !== 1'b0)
        begin n_err++; $display("FAIL hold_sum: got %h/%b expected 0000000100000000/0", sum, crout); end
        edge_wait();
        n_vec++;
        if (sum !== 64'd10) begin n_err++; $display("FAIL hold_next: got %h expected %h", sum, 64'd10); end
    endtask

    task automatic test_back_to_back();
        op1 = 64'd1; op2 = 64'd2;
        edge_wait();
        op1 = 64'd3; op2 = 64'd4;
        edge_wait();
        n_vec++;
        if (sum !== 64'd3) begin n_err++; $display("FAIL b2b_0: got %0d expected 3", sum); end
        op1 = 64'd5; op2 = 64'd6;
        edge_wait();
        n_vec++;
        if (sum !== 64'd7) begin n_err++; $display("FAIL b2b_1: got %0d expected 7", sum); end
        edge_wait();
        n_vec++;
        if (sum !== 64'd11) begin n_err++; $display("FAIL b2b_2: got %0d expected 11", sum); end
    endtask

    task automatic test_reset_mid();
        op1 = 64'd1; op2 = 64'd2;
        edge_wait();
        op1 = 64'd3; op2 = 64'd4;
        edge_wait();
        n_vec++;
        if (sum !== 64'd3) begin n_err++; $display("FAIL rmid_pre: got %0d expected 3", sum); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (sum !== 64'h0 || crout !== 1'b0)
        begin n_err++; $display("FAIL rmid_async: got %h/%b expected 0/0", sum, crout); end
        op1 = 64'h100; op2 = 64'h200;
        #2;
        reset = 1'b0;
        edge_wait();
        n_vec++;
        if (sum !== 64'h0) begin n_err++; $display("FAIL rmid_stale: got %h expected 0", sum); end
        edge_wait();
        n_vec++;
        if (sum !== 64'h300) begin n_err++; $display("FAIL rmid_fresh: got %h expected 300", sum); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_full_ripple();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
